branch_resolve: RTL
===================

Name: branch_resolve

Overview:
- Consumes the 2-bit zero-compare result {A==0, A>0} from the compare-against-zero stage.
- Resolves HMMM control-flow instructions (jumpn, jeqzn, jnezn, jgtzn, jltzn, calln, jumpr) into a registered next-PC, a taken flag and link-register write data.
- Sits between execute and fetch. Drives a one-cycle redirect pulse and discards wrong-path instructions already in flight after a taken branch.

Parameters:
- AW, 8, PC/address width; HMMM has 256 words of memory.
- SQUASH_DEPTH, 2, number of younger accepted instructions discarded after a taken branch; 0 disables squashing.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept this cycle
- in_op  input  3  0 NONE, 1 JUMPN, 2 JEQZN, 3 JNEZN, 4 JGTZN, 5 JLTZN, 6 CALLN, 7 JUMPR
- in_comp  input  2  {eq, gt} from the zero comparator
- in_pc  input  AW  PC of this instruction
- in_target  input  AW  immediate target N
- in_rdata  input  16  register value rX, used by JUMPR
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_taken  output  1  branch taken
- out_next_pc  output  AW  resolved next PC
- out_link_we  output  1  write the link register (CALLN)
- out_link_data  output  16  zero-extended in_pc+1
- redirect  output  1  one-cycle fetch redirect pulse
- redirect_pc  output  AW  target accompanying redirect
- squashing  output  1  block is in the SQUASH state

Behaviour:
- Reset (async, any cycle): all outputs 0, state=RUN, squash counter 0. An in-flight result is lost.
- Accept: accept = in_valid && in_ready.
  - RUN: in_ready = !out_valid || out_ready.
  - SQUASH: in_ready = 1.
- Conditions from in_comp:
  - eq = in_comp[1]
  - gt = in_comp[0] && !in_comp[1]
  - lt = !in_comp[1] && !in_comp[0]
  - 2'b11 is illegal; eq takes priority and gt is ignored.
- Taken decision:
  - JUMPN, CALLN, JUMPR: always taken.
  - JEQZN: eq. JNEZN: !eq. JGTZN: gt. JLTZN: lt.
  - NONE: never taken.
- Next PC:
  - Taken: in_target, or in_rdata[AW-1:0] for JUMPR.
  - Not taken: in_pc+1, modulo 2^AW. Example: 8'hFF+1 -> 8'h00.
- Link: out_link_we=1 only for CALLN. out_link_data = {zeros, in_pc} + 1, computed at 16 bits (no wrap at AW).
- Latency: one cycle. Outputs are registered on the accepting edge.
- Output register: holds while out_valid && !out_ready. out_valid clears on out_ready when no new accept occurs that cycle. Simultaneous drain and accept in RUN loads the new result; out_valid stays 1.
- redirect:
  - High exactly one cycle, the cycle after a taken accept in RUN.
  - Independent of out_ready.
  - redirect_pc = the registered next PC.
- State machine:
  - RUN -> SQUASH on a taken accept when SQUASH_DEPTH>0. Counter loads SQUASH_DEPTH.
  - SQUASH: each accept is discarded (no output register write, no redirect, taken branches ignored) and decrements the counter. Counter counts accepted transfers, not cycles.
  - SQUASH -> RUN when an accept occurs with counter==1. The next accept is processed normally.
  - While in SQUASH, a held output still drains via out_ready.
- squashing = (state==SQUASH).

Test Plan:
- JEQZN, comp=2'b10, pc=8'h10, target=8'h40 -> next cycle: out_valid=1, out_taken=1, out_next_pc=8'h40, redirect=1 for exactly one cycle, squashing=1.
- JGTZN, comp=2'b00, pc=8'hFF, SQUASH_DEPTH=2 -> out_taken=0, out_next_pc=8'h00, redirect=0. Then JLTZN with comp=2'b00 -> taken.
- CALLN, pc=8'h22, target=8'h80 -> out_link_we=1, out_link_data=16'h0023, out_next_pc=8'h80. The following two accepted instructions are discarded, including a JUMPN; the third is resolved normally.
- JUMPR, rdata=16'h1234 -> out_next_pc=8'h34. comp=2'b11 with JGTZN -> not taken; with JEQZN -> taken.
- Hold out_ready=0 for 3 cycles with a pending result -> in_ready=0 in RUN and outputs stable. Raising out_ready with in_valid=1 accepts and replaces in the same cycle.
- Assert reset while squashing=1 with a valid output -> out_valid=0, redirect=0, squashing=0 immediately (asynchronous). After release, the first accept is resolved normally.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution stage: turns a zero-compare result plus an HMMM control-flow op into a
// registered next-PC, taken flag, link write and a one-cycle fetch redirect, then squashes wrong-path work.
module branch_resolve #(
    parameter int AW           = 8,
    parameter int SQUASH_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [1:0]    in_comp,
    input  logic [AW-1:0] in_pc,
    input  logic [AW-1:0] in_target,
    input  logic [15:0]   in_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_taken,
    output logic [AW-1:0] out_next_pc,
    output logic          out_link_we,
    output logic [15:0]   out_link_data,
    output logic          redirect,
    output logic [AW-1:0] redirect_pc,
    output logic          squashing
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_JUMPN = 3'd1;
    localparam logic [2:0] OP_JEQZN = 3'd2;
    localparam logic [2:0] OP_JNEZN = 3'd3;
    localparam logic [2:0] OP_JGTZN = 3'd4;
    localparam logic [2:0] OP_JLTZN = 3'd5;
    localparam logic [2:0] OP_CALLN = 3'd6;
    localparam logic [2:0] OP_JUMPR = 3'd7;

    localparam int CW = (SQUASH_DEPTH > 1) ? $clog2(SQUASH_DEPTH + 1) : 1;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          load;
    logic          eq, gt, lt;
    logic          taken;
    logic [AW-1:0] next_pc;
    logic [15:0]   link_data;
    logic          unused_rdata;

    // Only the low AW bits of rX can address memory.
    assign unused_rdata = ^in_rdata[15:AW];

    // 2'b11 cannot come from a real comparator; eq wins so gt is masked.
    assign eq = in_comp[1];
    assign gt = in_comp[0] && !in_comp[1];
    assign lt = !in_comp[1] && !in_comp[0];

    always_comb begin
        taken = 1'b0;
        case (in_op)
            OP_JUMPN, OP_CALLN, OP_JUMPR: taken = 1'b1;
            OP_JEQZN: taken = eq;
            OP_JNEZN: taken = !eq;
            OP_JGTZN: taken = gt;
            OP_JLTZN: taken = lt;
            OP_NONE:  taken = 1'b0;
            default:  taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = in_pc + AW'(1);
        if (taken) begin
            next_pc = (in_op == OP_JUMPR) ? in_rdata[AW-1:0] : in_target;
        end
    end

    // Link data is the full 16-bit pc+1, so 8'hFF links to 16'h0100.
    assign link_data = 16'(in_pc) + 16'd1;

    // While squashing, the output register is untouched, so input is always welcome.
    assign in_ready = (state == SQUASH) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign squashing = (state == SQUASH);
    assign redirect_pc = out_next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    load = 1'b1;
                    if (taken && (SQUASH_DEPTH > 0)) begin
                        state_nxt = SQUASH;
                        cnt_nxt   = CW'(SQUASH_DEPTH);
                    end
                end
            end
            SQUASH: begin
                // Counts accepted transfers; idle cycles leave the window open.
                if (accept) begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_taken     <= 1'b0;
            out_next_pc   <= '0;
            out_link_we   <= 1'b0;
            out_link_data <= '0;
            redirect      <= 1'b0;
        end else begin
            redirect <= load && taken;
            if (load) begin
                out_valid     <= 1'b1;
                out_taken     <= taken;
                out_next_pc   <= next_pc;
                out_link_we   <= (in_op == OP_CALLN);
                out_link_data <= link_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
